// File: rtl/deemph_iir.sv
// FM de-emphasis: first-order IIR y[n] = deq(X0*x[n]) + deq(X1*x[n-1]) + deq(Y1*y[n-1])
// with FIFO handshakes on both sides, one time-shared signed multiplier and
// optional output decimation (one write per DECIMATION computed samples).
module deemph_iir #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    QUANT_BITS = 10,
  parameter logic [DATA_WIDTH-1:0] X0_COEFF   = 32'h000000B2,
  parameter logic [DATA_WIDTH-1:0] X1_COEFF   = 32'h000000B2,
  parameter logic [DATA_WIDTH-1:0] Y1_COEFF   = 32'hFFFFFD66,
  parameter int                    DECIMATION = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_in_empty,
  output logic                         x_in_rd_en,
  output logic signed [DATA_WIDTH-1:0] y_out,
  input  logic                         y_out_full,
  output logic                         y_out_wr_en
);

  typedef enum logic [2:0] {
    S_READ,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_WRITE
  } state_t;

  localparam logic [7:0] DECIM_LAST = 8'(DECIMATION - 1);

  state_t                         state_reg, state_next;
  logic signed [DATA_WIDTH-1:0]   x_hist_reg, x_hist_next;
  logic signed [DATA_WIDTH-1:0]   y_hist_reg, y_hist_next;
  logic signed [DATA_WIDTH-1:0]   acc_reg, acc_next;
  logic signed [DATA_WIDTH-1:0]   x_cur_reg, x_cur_next;
  logic signed [DATA_WIDTH-1:0]   y_out_reg, y_out_next;
  logic [7:0]                     decim_cnt_reg, decim_cnt_next;

  logic signed [DATA_WIDTH-1:0]   mul_coef;
  logic signed [DATA_WIDTH-1:0]   mul_op;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [DATA_WIDTH-1:0]   deq;
  logic                           decim_last;

  // Select the coefficient/operand pair for the single multiplier from the state
  always_comb begin
    mul_coef = $signed(X0_COEFF);
    mul_op   = x_cur_reg;
    case (state_reg)
      S_MUL1: begin
        mul_coef = $signed(X1_COEFF);
        mul_op   = x_hist_reg;
      end
      S_MUL2: begin
        mul_coef = $signed(Y1_COEFF);
        mul_op   = y_hist_reg;
      end
      default: ;
    endcase
  end

  // Full-width product, floor-shift dequantize, then truncate to the sample width
  assign product    = mul_coef * mul_op;
  assign deq        = DATA_WIDTH'(product >>> QUANT_BITS);
  assign decim_last = (decim_cnt_reg == DECIM_LAST);

  // While a write is strobed the output shows the fresh result, otherwise the last written one
  assign y_out = y_out_wr_en ? acc_reg : y_out_reg;

  // Next-state and handshake decode
  always_comb begin
    state_next     = state_reg;
    x_hist_next    = x_hist_reg;
    y_hist_next    = y_hist_reg;
    acc_next       = acc_reg;
    x_cur_next     = x_cur_reg;
    y_out_next     = y_out_reg;
    decim_cnt_next = decim_cnt_reg;
    x_in_rd_en     = 1'b0;
    y_out_wr_en    = 1'b0;
    case (state_reg)
      S_READ: begin
        if (!x_in_empty) begin
          x_in_rd_en = 1'b1;
          x_cur_next = x_in;
          state_next = S_MUL0;
        end
      end
      S_MUL0: begin
        acc_next   = deq;
        state_next = S_MUL1;
      end
      S_MUL1: begin
        acc_next   = acc_reg + deq;
        state_next = S_MUL2;
      end
      S_MUL2: begin
        acc_next   = acc_reg + deq;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!decim_last) begin
          // Computed but not written: histories still advance
          y_hist_next    = acc_reg;
          x_hist_next    = x_cur_reg;
          decim_cnt_next = decim_cnt_reg + 8'd1;
          state_next     = S_READ;
        end else if (!y_out_full) begin
          y_out_wr_en    = 1'b1;
          y_out_next     = acc_reg;
          y_hist_next    = acc_reg;
          x_hist_next    = x_cur_reg;
          decim_cnt_next = 8'd0;
          state_next     = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight sample
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_READ;
      x_hist_reg    <= '0;
      y_hist_reg    <= '0;
      acc_reg       <= '0;
      x_cur_reg     <= '0;
      y_out_reg     <= '0;
      decim_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      x_hist_reg    <= x_hist_next;
      y_hist_reg    <= y_hist_next;
      acc_reg       <= acc_next;
      x_cur_reg     <= x_cur_next;
      y_out_reg     <= y_out_next;
      decim_cnt_reg <= decim_cnt_next;
    end
  end

endmodule

// File: tb/tb_deemph_iir.sv
// Directed bench for deemph_iir: three instances (default, DECIMATION=2, X0=1.0)
// driven through one shared clock/reset with hand-computed expected outputs.
module tb_deemph_iir;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x_in    [3];
  logic        x_empty [3];
  logic        rd_en   [3];
  logic [31:0] y_out   [3];
  logic        y_full  [3];
  logic        wr_en   [3];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  // Cycle counter used to measure latencies
  always @(posedge clock) cyc <= cyc + 1;

  deemph_iir u_dut (
    .clock(clock), .reset(reset),
    .x_in(x_in[0]), .x_in_empty(x_empty[0]), .x_in_rd_en(rd_en[0]),
    .y_out(y_out[0]), .y_out_full(y_full[0]), .y_out_wr_en(wr_en[0])
  );

  deemph_iir #(.DECIMATION(2)) u_dec (
    .clock(clock), .reset(reset),
    .x_in(x_in[1]), .x_in_empty(x_empty[1]), .x_in_rd_en(rd_en[1]),
    .y_out(y_out[1]), .y_out_full(y_full[1]), .y_out_wr_en(wr_en[1])
  );

  deemph_iir #(.X0_COEFF(32'h00000400)) u_wrap (
    .clock(clock), .reset(reset),
    .x_in(x_in[2]), .x_in_empty(x_empty[2]), .x_in_rd_en(rd_en[2]),
    .y_out(y_out[2]), .y_out_full(y_full[2]), .y_out_wr_en(wr_en[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  tag, $signed(obs), obs, $signed(exp), exp);
  endtask

  task automatic reset_all();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer one sample, wait for its pop, then watch 6 cycles for the write
  task automatic run_sample(input int k, input string tag, input logic [31:0] xv,
                            input bit want_wr, input logic [31:0] exp_y);
    int n, t_pop, n_wr, n_rd, lat;
    logic [31:0] got;
    @(negedge clock);
    x_in[k] = xv;
    x_empty[k] = 1'b0;
    #1;
    n = 0;
    while (!rd_en[k] && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({tag, "_pop"}, 32'(rd_en[k]), 32'd1);
    t_pop = cyc;
    n_wr = 0; n_rd = 0; lat = 0; got = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (i == 1) x_empty[k] = 1'b1;
      #1;
      if (rd_en[k]) n_rd++;
      if (wr_en[k]) begin
        n_wr++;
        if (n_wr == 1) begin
          lat = cyc - t_pop;
          got = y_out[k];
        end
      end
    end
    $display("sample %s: x=%0d writes=%0d y=%0d latency=%0d", tag, $signed(xv), n_wr, $signed(got), lat);
    check({tag, "_nwr"}, 32'(n_wr), want_wr ? 32'd1 : 32'd0);
    check({tag, "_spurious_rd"}, 32'(n_rd), 32'd0);
    if (want_wr) begin
      check({tag, "_lat"}, 32'(lat), 32'd4);
      check({tag, "_y"}, got, exp_y);
    end
  endtask

  // Idle cycles with the FIFO empty: no strobes may appear
  task automatic idle(input int k, input int ncyc, input string tag);
    int n_strobe;
    n_strobe = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      #1;
      if (rd_en[k] || wr_en[k]) n_strobe++;
    end
    check({tag, "_idle_strobes"}, 32'(n_strobe), 32'd0);
  endtask

  initial begin
    int n, t_pop, bad_wr, bad_rd, n_wr;
    bit drop_empty;
    logic [31:0] w [4];

    for (int k = 0; k < 3; k++) begin
      x_in[k] = '0;
      x_empty[k] = 1'b1;
      y_full[k] = 1'b0;
    end
    reset_all();

    // Reset state of every instance
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_y%0d", k), y_out[k], 32'd0);
      check($sformatf("rst_wr%0d", k), 32'(wr_en[k]), 32'd0);
      check($sformatf("rst_rd%0d", k), 32'(rd_en[k]), 32'd0);
    end

    // DECIMATION=2: only samples 2 and 4 are written
    run_sample(1, "dec_s1", 32'd1024, 1'b0, 32'd0);
    run_sample(1, "dec_s2", 32'd0, 1'b1, 32'd62);
    run_sample(1, "dec_s3", 32'd0, 1'b0, 32'd0);
    run_sample(1, "dec_s4", 32'd0, 1'b1, 32'd26);

    // X0 = 1.0: full-scale input twice, intermediate sum wraps
    run_sample(2, "wrap_s1", 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF);
    run_sample(2, "wrap_s2", 32'h7FFFFFFF, 1'b1, 32'd1124073470);

    // Impulse with samples spaced roughly 20 cycles apart
    run_sample(0, "imp0", 32'd1024, 1'b1, 32'd178);
    idle(0, 14, "imp0");
    run_sample(0, "imp1", 32'd0, 1'b1, 32'd62);
    idle(0, 14, "imp1");
    run_sample(0, "imp2", 32'd0, 1'b1, -32'sd41);
    idle(0, 14, "imp2");
    run_sample(0, "imp3", 32'd0, 1'b1, 32'd26);

    // Backpressure: full held 10 cycles past the ready result, next sample waiting
    reset_all();
    y_full[0] = 1'b1;
    @(negedge clock);
    x_in[0] = 32'd1024;
    x_empty[0] = 1'b0;
    #1;
    n = 0;
    while (!rd_en[0] && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("bp_pop", 32'(rd_en[0]), 32'd1);
    t_pop = cyc;
    bad_wr = 0; bad_rd = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clock);
      if (i == 1) x_in[0] = 32'd0;
      #1;
      if (wr_en[0]) bad_wr++;
      if (rd_en[0]) bad_rd++;
    end
    check("bp_held_wr", 32'(bad_wr), 32'd0);
    check("bp_held_rd", 32'(bad_rd), 32'd0);
    n_wr = 0;
    drop_empty = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) y_full[0] = 1'b0;
      if (drop_empty) x_empty[0] = 1'b1;
      #1;
      if (rd_en[0]) drop_empty = 1'b1;
      if (wr_en[0]) begin
        if (n_wr < 4) w[n_wr] = y_out[0];
        n_wr++;
      end
    end
    $display("backpressure: writes=%0d first=%0d second=%0d", n_wr, $signed(w[0]), $signed(w[1]));
    check("bp_nwr", 32'(n_wr), 32'd2);
    check("bp_first", w[0], 32'd178);
    check("bp_second", w[1], 32'd62);

    // Negative input: floor rounding gives deq(178 * -1) = -1
    reset_all();
    run_sample(0, "neg", 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);

    // Reset while in S_MUL1 abandons the sample and clears history
    reset_all();
    run_sample(0, "rst_pre", 32'd1024, 1'b1, 32'd178);
    @(negedge clock);
    x_in[0] = 32'd0;
    x_empty[0] = 1'b0;
    #1;
    n = 0;
    while (!rd_en[0] && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("rst_mid_pop", 32'(rd_en[0]), 32'd1);
    @(negedge clock);
    x_empty[0] = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("rst_mid_y", y_out[0], 32'd0);
    check("rst_mid_wr", 32'(wr_en[0]), 32'd0);
    reset = 1'b0;
    idle(0, 8, "rst_mid");
    run_sample(0, "rst_post", 32'd1024, 1'b1, 32'd178);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
